// File: rtl/sym_fir_serial.sv
// Odd-length symmetric FIR. One shared multiplier folds mirrored taps, giving one MAC per unique coefficient.
// Accept at E0 and out_valid follows edge E(H+1). in_ready is high only in IDLE, so samples are spaced H+2 clocks apart.
module sym_fir_serial #(
    parameter int DATA_W = 10,
    parameter int COEF_W = 8,
    parameter int TAPS   = 31,
    parameter int SHIFT  = 10,
    localparam int H     = (TAPS + 1) / 2,
    localparam int AW    = $clog2(H)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     coef_wr_err,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     primed
);
    localparam int ACC_W = DATA_W + 1 + COEF_W + $clog2(H) + 1;
    localparam int PW    = COEF_W + DATA_W + 2;
    localparam int DIW   = $clog2(TAPS);
    localparam int CW    = $clog2(TAPS + 1);
    localparam logic signed [ACC_W-1:0] RND  = ACC_W'(1) <<< (SHIFT - 1);
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << DATA_W) - 1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t                    r_state, w_state_nxt;
    logic [DATA_W-1:0]         r_dline [TAPS];
    logic signed [COEF_W-1:0]  r_coef [H];
    logic signed [ACC_W-1:0]   r_acc;
    logic [AW-1:0]             r_idx;
    logic [CW-1:0]             r_cnt;
    logic                      r_out_vld;
    logic [DATA_W-1:0]         r_out_dat;
    logic                      r_wr_err;

    logic                      w_hs;
    logic                      w_last;
    logic                      w_wr_ok;
    logic [DIW-1:0]            w_near;
    logic [DIW-1:0]            w_mirror;
    logic [DATA_W:0]           w_pair;
    logic signed [PW-1:0]      w_prod;
    logic signed [ACC_W-1:0]   w_rnd;
    logic signed [ACC_W-1:0]   w_scaled;
    logic [DATA_W-1:0]         w_sat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_MAC;
            end
            S_MAC:   if (w_last) w_state_nxt = S_OUT;
            S_OUT:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_hs    = in_valid & in_ready;
    assign w_last  = (r_idx == AW'(H - 1));
    assign w_wr_ok = coef_we && (r_state == S_IDLE) && ({1'b0, coef_addr} < (AW + 1)'(H));

    // Fold mirrored taps before the multiply; the centre tap has no partner.
    assign w_near   = DIW'(r_idx);
    assign w_mirror = DIW'(TAPS - 1) - w_near;
    assign w_pair   = w_last ? {1'b0, r_dline[w_near]}
                             : {1'b0, r_dline[w_near]} + {1'b0, r_dline[w_mirror]};
    assign w_prod   = PW'(r_coef[r_idx]) * PW'($signed({1'b0, w_pair}));

    assign w_rnd    = r_acc + RND;
    assign w_scaled = w_rnd >>> SHIFT;

    always_comb begin
        w_sat = w_scaled[DATA_W-1:0];
        if (w_scaled < 0)         w_sat = '0;
        else if (w_scaled > MAXV) w_sat = '1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
            r_idx <= '0;
            r_cnt <= '0;
            for (int i = 0; i < TAPS; i++) r_dline[i] <= '0;
        end else if (w_hs) begin
            r_acc      <= '0;
            r_idx      <= '0;
            r_dline[0] <= in_data;
            for (int i = 1; i < TAPS; i++) r_dline[i] <= r_dline[i-1];
            if (r_cnt != CW'(TAPS)) r_cnt <= r_cnt + CW'(1);
        end else if (r_state == S_MAC) begin
            r_acc <= r_acc + ACC_W'(w_prod);
            if (!w_last) r_idx <= r_idx + AW'(1);
        end
    end

    // A write on a handshake edge lands before the first MAC reads it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < H; i++) r_coef[i] <= '0;
        end else if (w_wr_ok) begin
            r_coef[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
            r_wr_err  <= 1'b0;
        end else begin
            r_out_vld <= (r_state == S_OUT);
            r_wr_err  <= coef_we & ~w_wr_ok;
            if (r_state == S_OUT) r_out_dat <= w_sat;
        end
    end

    assign out_valid   = r_out_vld;
    assign out_data    = r_out_dat;
    assign coef_wr_err = r_wr_err;
    assign primed      = (r_cnt == CW'(TAPS));
endmodule

// File: doc/sym_fir_serial.md
Name: sym_fir_serial

Overview:
- Parametrised successor to the fixed 31-tap FIR in the pulse-sensor signal chain. It sits between the SPI sample receiver and the peak finder / DAC path.
- Implements an odd-length, linear-phase (symmetric) FIR with runtime-writable signed coefficients.
- Uses one shared multiplier, time-multiplexed over the half-length.
- Adds a valid/ready sample handshake, round-to-nearest scaling, output saturation and a delay-line "primed" indicator.

Parameters:
- DATA_W, 10, unsigned sample width (input and output).
- COEF_W, 8, signed two's-complement coefficient width.
- TAPS, 31, filter length; must be odd and >= 3. H = (TAPS+1)/2 unique coefficients.
- SHIFT, 10, right-shift applied to the accumulator (coefficient fixed-point scale); must be >= 1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  sample offered
- in_ready  out  1  block can accept a sample this cycle
- in_data  in  DATA_W  unsigned sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(H)  coefficient index 0..H-1; index H-1 is the centre tap
- coef_data  in  COEF_W  signed coefficient value
- coef_wr_err  out  1  one-cycle pulse: write rejected
- out_valid  out  1  one-cycle pulse: out_data updated
- out_data  out  DATA_W  filtered, rounded, saturated sample
- primed  out  1  high once TAPS samples have been accepted since reset

Behaviour:
- Reset (async) values:
  - State = IDLE; accumulator = 0; index = 0; all TAPS delay-line entries = 0.
  - All coefficients = 0; primed-counter = 0.
  - out_valid = 0, out_data = 0, coef_wr_err = 0, primed = 0.
- States:
  - IDLE: in_ready = 1, decoded combinationally from state. Handshake fires when in_valid & in_ready at a rising edge. That edge shifts the delay line (v[0] newest = in_data, v[TAPS-1] oldest dropped), clears the accumulator, sets index = 0, and moves to MAC.
  - MAC: in_ready = 0. One edge per index k = 0..H-1.
    - For k < H-1: acc += coef[k] * (v[k] + v[TAPS-1-k]). The pair sum is DATA_W+1 bits unsigned and zero-extended before the signed multiply.
    - For k = H-1: acc += coef[H-1] * v[H-1].
    - After k = H-1, move to OUT.
  - OUT: in_ready = 0.
    - r = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift).
    - out_data <= 0 if r < 0; 2^DATA_W-1 if r > 2^DATA_W-1; else r.
    - out_valid <= 1 for exactly one cycle; return to IDLE.
- Accumulator width ACC_W = DATA_W + 1 + COEF_W + $clog2(H) + 1, signed. Intermediate overflow is impossible.
- Latency and throughput:
  - Accept at edge E0. out_valid is high in the cycle after edge E(H+1).
  - out_data is held between updates.
  - Earliest next accept is edge E(H+2), so minimum sample spacing is H+2 clocks (18 at defaults).
- in_data is sampled only at the handshake edge. Changes while in_ready = 0 are ignored, and in_valid may stay high.
- Coefficient writes:
  - Accepted only in IDLE, on the edge where coef_we = 1.
  - If a sample handshake happens on the same edge, the write applies first and that sample uses the new value.
  - A write with coef_we = 1 in MAC or OUT is dropped and coef_wr_err pulses one cycle.
  - A write with coef_addr >= H (non-power-of-two H) is dropped and coef_wr_err pulses.
- primed: a saturating counter increments on each handshake. primed = 1 once the count reaches TAPS, then stays high until reset.
- Reset mid-MAC or mid-OUT: the result is discarded, no out_valid is produced, and all state returns to reset values.

Test Plan:
- Impulse: defaults; coef[15] = 64, others 0, SHIFT = 10. Feed 1000 then zeros. -> 15th output after the impulse (delay-line centre) = (64000+512)>>10 = 63; all other outputs = 0.
- DC lowpass:
  - Write coef[0..15] = 3,4,6,8,12,17,23,29,36,43,50,56,61,65,67,68 (sum 1028).
  - Feed constant 1000.
  - -> Outputs 1..30 ramp upward; primed rises on the 31st accept; 31st and later outputs = 1004.
- Saturation high: all coef = 127, input 1023 steady -> out_data = 1023 once primed.
- Saturation low: coef[15] = -128, others 0, input 500 -> out_data = 0.
- Handshake/timing: in_valid held high with incrementing data.
  - -> in_ready high exactly 1 of every 18 cycles; out_valid 17 cycles after each accept; no sample skipped or duplicated.
  - A coef_we during MAC -> coef_wr_err pulse, coefficient unchanged (readback via impulse test).
- Reset mid-MAC at index 7 -> out_valid never fires for that sample; out_data = 0; primed = 0; next impulse test matches a fresh run.
